// File: rtl/engine_csr_pkg.sv
// Shared definitions for the engine CSR bank: address-map offsets, decode
// result type and the byte-lane merge used by every strobed register.
package engine_csr_pkg;

  // Widest register the byte-merge helper handles; DATA_W must not exceed it.
  localparam int CSR_MAX_W = 256;
  localparam int CSR_MAX_B = CSR_MAX_W / 8;

  typedef enum logic [2:0] {
    DEC_CTRL,
    DEC_STATUS,
    DEC_IRQ_EN,
    DEC_ID,
    DEC_UNMAPPED
  } csr_decode_e;

  function automatic int OFS_STATUS(input int n);
    return n;
  endfunction

  function automatic int OFS_IRQ_EN(input int n);
    return n + 1;
  endfunction

  function automatic int OFS_ID(input int n);
    return n + 2;
  endfunction

  // Byte k of the result comes from new_v when strobe[k] is set, else old_v.
  function automatic logic [CSR_MAX_W-1:0] byte_merge(
    input logic [CSR_MAX_W-1:0] old_v,
    input logic [CSR_MAX_W-1:0] new_v,
    input logic [CSR_MAX_B-1:0] strobe
  );
    logic [CSR_MAX_W-1:0] res;
    res = old_v;
    for (int k = 0; k < CSR_MAX_B; k++) begin
      if (strobe[k]) res[k*8 +: 8] = new_v[k*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/engine_csr_sticky_status.sv
// Sticky event register: status_in bits set, byte-strobed write-1 clears,
// and a set arriving in the same cycle as its clear keeps the bit at 1.
module engine_csr_sticky_status
  import engine_csr_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear_en,
  input  logic [DATA_W-1:0]   clear_data,
  input  logic [DATA_W/8-1:0] clear_strobe,
  input  logic [DATA_W-1:0]   status_in,
  output logic [DATA_W-1:0]   status
);

  logic [DATA_W-1:0] clear_mask;

  always_comb begin
    clear_mask = '0;
    if (clear_en) begin
      clear_mask = DATA_W'(byte_merge('0, CSR_MAX_W'(clear_data), CSR_MAX_B'(clear_strobe)));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      status <= '0;
    end else begin
      status <= (status & ~clear_mask) | status_in;
    end
  end

endmodule

// File: rtl/engine_csr_bank.sv
// Word-addressed CSR bank: NUM_CTRL control registers, sticky STATUS,
// IRQ_EN and a constant ID, with registered reads and error pulses.
module engine_csr_bank
  import engine_csr_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 33,
  parameter int                NUM_CTRL   = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 'hAA,
  parameter logic [DATA_W-1:0] CTRL_RESET = '0,
  parameter logic [DATA_W-1:0] ID_VALUE   = 'hE5C0_0001
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            address,
  input  logic                         write_enable,
  input  logic [DATA_W-1:0]            write_data,
  input  logic [DATA_W/8-1:0]          write_strobe,
  input  logic                         read_enable,
  output logic [DATA_W-1:0]            read_data,
  output logic                         read_valid,
  output logic                         access_error,
  output logic [NUM_CTRL*DATA_W-1:0]   ctrl_out,
  output logic [NUM_CTRL-1:0]          ctrl_wr_pulse,
  input  logic [DATA_W-1:0]            status_in,
  output logic                         irq
);

  // Bus protocol: write_enable and read_enable are single-cycle requests with
  // no back-pressure; every request is taken at the edge where it is high.
  // read_valid marks the one cycle in which read_data carries the answer.

  localparam logic [ADDR_W-1:0] OFS_ST = ADDR_W'(OFS_STATUS(NUM_CTRL));
  localparam logic [ADDR_W-1:0] OFS_IE = ADDR_W'(OFS_IRQ_EN(NUM_CTRL));
  localparam logic [ADDR_W-1:0] OFS_RO = ADDR_W'(OFS_ID(NUM_CTRL));

  logic [NUM_CTRL-1:0][DATA_W-1:0] ctrl_q;
  logic [DATA_W-1:0]               irq_en_q;
  logic [DATA_W-1:0]               status_q;
  logic [ADDR_W-1:0]               offset;
  csr_decode_e                     dec;
  logic [NUM_CTRL-1:0]             ctrl_hit;
  logic                            irq_en_wr;
  logic                            status_clr;
  logic                            err_next;
  logic [DATA_W-1:0]               rd_mux;

  // Addresses below the base are rejected before the wrapped offset is used.
  always_comb begin
    offset = address - BASE_ADDR;
    dec    = DEC_UNMAPPED;
    if (address >= BASE_ADDR) begin
      if (offset < ADDR_W'(NUM_CTRL)) dec = DEC_CTRL;
      else if (offset == OFS_ST)      dec = DEC_STATUS;
      else if (offset == OFS_IE)      dec = DEC_IRQ_EN;
      else if (offset == OFS_RO)      dec = DEC_ID;
    end
  end

  always_comb begin
    ctrl_hit = '0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      ctrl_hit[i] = write_enable && (|write_strobe) && (dec == DEC_CTRL)
                    && (offset == ADDR_W'(i));
    end
    irq_en_wr  = write_enable && (dec == DEC_IRQ_EN);
    status_clr = write_enable && (dec == DEC_STATUS);
    err_next   = (read_enable && (dec == DEC_UNMAPPED))
               || (write_enable && ((dec == DEC_UNMAPPED) || (dec == DEC_ID)));
  end

  // Reads see register contents before this edge's write or status update.
  always_comb begin
    rd_mux = '0;
    case (dec)
      DEC_CTRL: begin
        for (int i = 0; i < NUM_CTRL; i++) begin
          if (offset == ADDR_W'(i)) rd_mux = ctrl_q[i];
        end
      end
      DEC_STATUS: rd_mux = status_q;
      DEC_IRQ_EN: rd_mux = irq_en_q;
      DEC_ID:     rd_mux = ID_VALUE;
      default:    rd_mux = '0;
    endcase
  end

  engine_csr_sticky_status #(
    .DATA_W(DATA_W)
  ) u_status (
    .clock       (clock),
    .reset       (reset),
    .clear_en    (status_clr),
    .clear_data  (write_data),
    .clear_strobe(write_strobe),
    .status_in   (status_in),
    .status      (status_q)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q        <= {NUM_CTRL{CTRL_RESET}};
      irq_en_q      <= '0;
      read_data     <= '0;
      read_valid    <= 1'b0;
      access_error  <= 1'b0;
      ctrl_wr_pulse <= '0;
      irq           <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (ctrl_hit[i]) begin
          ctrl_q[i] <= DATA_W'(byte_merge(CSR_MAX_W'(ctrl_q[i]), CSR_MAX_W'(write_data),
                                          CSR_MAX_B'(write_strobe)));
        end
      end
      if (irq_en_wr) begin
        irq_en_q <= DATA_W'(byte_merge(CSR_MAX_W'(irq_en_q), CSR_MAX_W'(write_data),
                                       CSR_MAX_B'(write_strobe)));
      end
      ctrl_wr_pulse <= ctrl_hit;
      read_valid    <= read_enable;
      if (read_enable) read_data <= rd_mux;
      access_error  <= err_next;
      irq           <= |(status_q & irq_en_q);
    end
  end

  assign ctrl_out = ctrl_q;

endmodule

// File: tb/tb_engine_csr_bank.sv
// Bench for engine_csr_bank: directed vector table, hand sequences, then
// random traffic against an address-map level reference model.
module tb_engine_csr_bank;

  localparam int DW = 32;
  localparam int AW = 33;
  localparam int N  = 4;
  localparam logic [AW-1:0] BASE = 33'hAA;
  localparam logic [DW-1:0] ID   = 32'hE5C0_0001;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [AW-1:0]     address = '0;
  logic              write_enable = 1'b0;
  logic [DW-1:0]     write_data = '0;
  logic [DW/8-1:0]   write_strobe = '0;
  logic              read_enable = 1'b0;
  logic [DW-1:0]     read_data;
  logic              read_valid;
  logic              access_error;
  logic [N*DW-1:0]   ctrl_out;
  logic [N-1:0]      ctrl_wr_pulse;
  logic [DW-1:0]     status_in = '0;
  logic              irq;

  always #5 clock = ~clock;

  engine_csr_bank dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .write_enable (write_enable),
    .write_data   (write_data),
    .write_strobe (write_strobe),
    .read_enable  (read_enable),
    .read_data    (read_data),
    .read_valid   (read_valid),
    .access_error (access_error),
    .ctrl_out     (ctrl_out),
    .ctrl_wr_pulse(ctrl_wr_pulse),
    .status_in    (status_in),
    .irq          (irq)
  );

  typedef struct {
    logic          rst;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wd;
    logic [3:0]    ws;
    logic          re;
    logic [DW-1:0] si;
  } stim_t;

  typedef struct {
    logic            valid;
    logic [DW-1:0]   data;
    logic            err;
    logic            irq;
    logic [N-1:0]    pulse;
    logic [N*DW-1:0] ctrl;
  } resp_t;

  typedef struct {
    stim_t         s;
    logic          valid;
    logic [DW-1:0] data;
    logic          err;
    logic          irq;
    logic [N-1:0]  pulse;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];
  vec_t tbl[$];

  logic [DW-1:0] m_ctrl[N];
  logic [DW-1:0] m_status;
  logic [DW-1:0] m_irq_en;
  logic [DW-1:0] m_last_rd;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: register map as plain arrays, one call per clock edge.
  task automatic model_step(input stim_t s, output resp_t r);
    longint        off;
    bit            unm;
    logic [DW-1:0] rv;
    logic [DW-1:0] clr;
    r.valid = 1'b0; r.data = '0; r.err = 1'b0; r.irq = 1'b0; r.pulse = '0; r.ctrl = '0;
    if (s.rst) begin
      for (int i = 0; i < N; i++) m_ctrl[i] = '0;
      m_status = '0; m_irq_en = '0; m_last_rd = '0;
      return;
    end
    off = longint'(s.addr) - longint'(BASE);
    unm = (off < 0) || (off > N + 2);
    rv  = '0;
    if (!unm) begin
      if (off < N)           rv = m_ctrl[off];
      else if (off == N)     rv = m_status;
      else if (off == N + 1) rv = m_irq_en;
      else                   rv = ID;
    end
    r.irq   = (m_status & m_irq_en) != 0;
    r.err   = (s.re && unm) || (s.we && (unm || off == N + 2));
    r.valid = s.re;
    if (s.re) m_last_rd = rv;
    r.data  = m_last_rd;
    clr = '0;
    if (s.we && !unm) begin
      if (off < N && s.ws != 0) r.pulse[off] = 1'b1;
      for (int k = 0; k < DW / 8; k++) begin
        if (s.ws[k]) begin
          if (off < N)           m_ctrl[off][k*8 +: 8] = s.wd[k*8 +: 8];
          else if (off == N)     clr[k*8 +: 8] = s.wd[k*8 +: 8];
          else if (off == N + 1) m_irq_en[k*8 +: 8] = s.wd[k*8 +: 8];
        end
      end
    end
    m_status = (m_status & ~clr) | s.si;
    for (int i = 0; i < N; i++) r.ctrl[i*DW +: DW] = m_ctrl[i];
  endtask

  task automatic apply(input stim_t s);
    reset        = s.rst;
    address      = s.addr;
    write_enable = s.we;
    write_data   = s.wd;
    write_strobe = s.ws;
    read_enable  = s.re;
    status_in    = s.si;
    @(posedge clock);
    #1;
  endtask

  function automatic stim_t mks(logic rst, logic [AW-1:0] addr, logic we, logic [DW-1:0] wd,
                                logic [3:0] ws, logic re, logic [DW-1:0] si);
    stim_t s;
    s.rst = rst; s.addr = addr; s.we = we; s.wd = wd; s.ws = ws; s.re = re; s.si = si;
    return s;
  endfunction

  function automatic vec_t mkv(logic rst, logic [AW-1:0] addr, logic we, logic [DW-1:0] wd,
                               logic [3:0] ws, logic re, logic [DW-1:0] si, logic v,
                               logic [DW-1:0] d, logic e, logic q, logic [N-1:0] p);
    vec_t t;
    t.s = mks(rst, addr, we, wd, ws, re, si);
    t.valid = v; t.data = d; t.err = e; t.irq = q; t.pulse = p;
    return t;
  endfunction

  // Runs one cycle with hand-derived expectations, keeping the model in step.
  task automatic run_vec(input string tag, input vec_t t);
    resp_t r;
    model_step(t.s, r);
    apply(t.s);
    check({tag, "_valid"}, read_valid, t.valid);
    if (t.valid) check({tag, "_rdata"}, read_data, t.data);
    check({tag, "_err"}, access_error, t.err);
    check({tag, "_irq"}, irq, t.irq);
    check({tag, "_pulse"}, ctrl_wr_pulse, t.pulse);
    check({tag, "_ctrl"}, ctrl_out, r.ctrl);
  endtask

  initial begin
    resp_t r;
    stim_t s;
    int    sel;

    // rst addr we wd ws re si | valid data err irq pulse
    tbl.push_back(mkv(1, 'hAA, 0, 0, 0, 0, 0,             0, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hAA, 0, 0, 0, 1, 0,             1, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hAB, 0, 0, 0, 1, 0,             1, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hAC, 0, 0, 0, 1, 0,             1, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hAD, 0, 0, 0, 1, 0,             1, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hAE, 0, 0, 0, 1, 0,             1, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hAF, 0, 0, 0, 1, 0,             1, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hB0, 0, 0, 0, 1, 0,             1, 32'hE5C0_0001, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hAA, 0, 0, 0, 0, 0,             0, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hAC, 1, 32'hAAAA_AAAA, 4'hF, 0, 0, 0, 0, 0, 0, 4'b0100));
    tbl.push_back(mkv(0, 'hAC, 1, 32'h1234_5678, 4'b0101, 0, 0, 0, 0, 0, 0, 4'b0100));
    tbl.push_back(mkv(0, 'hAC, 0, 0, 0, 1, 0,             1, 32'hAA34_AA78, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hAC, 1, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hAC, 0, 0, 0, 1, 0,             1, 32'hAA34_AA78, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hAF, 1, 32'h1, 4'hF, 0, 0,      0, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hAA, 0, 0, 0, 0, 32'h11,        0, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hAA, 0, 0, 0, 0, 0,             0, 0, 0, 1, 4'b0000));
    tbl.push_back(mkv(0, 'hAE, 0, 0, 0, 1, 0,             1, 32'h11, 0, 1, 4'b0000));
    tbl.push_back(mkv(0, 'hAE, 1, 32'h1, 4'hF, 0, 0,      0, 0, 0, 1, 4'b0000));
    tbl.push_back(mkv(0, 'hAE, 0, 0, 0, 1, 0,             1, 32'h10, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hAE, 1, 32'h10, 4'b0001, 0, 32'h10, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hAE, 0, 0, 0, 1, 0,             1, 32'h10, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hB1, 0, 0, 0, 1, 0,             1, 0, 1, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hA9, 0, 0, 0, 1, 0,             1, 0, 1, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hAA, 0, 0, 0, 0, 0,             0, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hB0, 1, 32'h0, 4'hF, 0, 0,      0, 0, 1, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hB0, 0, 0, 0, 1, 0,             1, 32'hE5C0_0001, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hB1, 1, 32'h5, 4'hF, 1, 0,      1, 0, 1, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hAA, 1, 32'hFFFF_FFFF, 4'hF, 1, 0, 1, 0, 0, 0, 4'b0001));
    tbl.push_back(mkv(0, 'hAA, 0, 0, 0, 1, 0,             1, 32'hFFFF_FFFF, 0, 0, 4'b0000));
    tbl.push_back(mkv(1, 'hAB, 1, 32'h5, 4'hF, 1, 0,      0, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hAA, 0, 0, 0, 1, 0,             1, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hAE, 0, 0, 0, 1, 0,             1, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hAF, 0, 0, 0, 1, 0,             1, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hAA, 1, 32'h77, 4'b0001, 1, 0,  1, 0, 0, 0, 4'b0001));
    tbl.push_back(mkv(1, 'hAA, 0, 0, 0, 0, 0,             0, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hAA, 0, 0, 0, 1, 0,             1, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(0, 33'h0, 0, 0, 0, 1, 0,            1, 0, 1, 0, 4'b0000));
    tbl.push_back(mkv(0, 33'h1_FFFF_FFFF, 0, 0, 0, 1, 0,  1, 0, 1, 0, 4'b0000));
    tbl.push_back(mkv(0, 33'h1_0000_00AA, 1, 32'h9, 4'hF, 0, 0, 0, 0, 1, 0, 4'b0000));
    tbl.push_back(mkv(0, 'hAA, 0, 0, 0, 1, 0,             1, 0, 0, 0, 4'b0000));

    for (int i = 0; i < tbl.size(); i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

    // read_valid lasts one cycle and read_data holds while idle
    run_vec("hold_wr", mkv(0, 'hAD, 1, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0, 0, 0, 4'b1000));
    run_vec("hold_rd", mkv(0, 'hAD, 0, 0, 0, 1, 0, 1, 32'hCAFE_F00D, 0, 0, 4'b0000));
    for (int i = 0; i < 3; i++) begin
      run_vec($sformatf("hold_idle%0d", i), mkv(0, 'hAD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
      check($sformatf("hold_data%0d", i), read_data, 32'hCAFE_F00D);
    end

    // random traffic against the model, reads tracked through exp_q
    for (int c = 0; c < 3000; c++) begin
      s.rst = ($urandom_range(0, 99) == 0);
      sel = $urandom_range(0, 19);
      if (sel == 0)      s.addr = AW'($urandom_range(0, 3));
      else if (sel == 1) s.addr = {1'b1, 32'($urandom())};
      else               s.addr = BASE - 2 + AW'($urandom_range(0, 10));
      s.we = ($urandom_range(0, 1) == 1);
      s.re = ($urandom_range(0, 1) == 1);
      s.wd = $urandom();
      s.ws = 4'($urandom_range(0, 15));
      s.si = ($urandom_range(0, 7) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
      model_step(s, r);
      if (s.re && !s.rst) exp_q.push_back(r.data);
      apply(s);
      check("rnd_valid", read_valid, r.valid);
      if (read_valid) begin
        if (exp_q.size() == 0) check("rnd_unexpected_valid", 1'b1, 1'b0);
        else check("rnd_rdata", read_data, exp_q.pop_front());
      end else begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        check("rnd_rdata_hold", read_data, r.data);
      end
      check("rnd_err", access_error, r.err);
      check("rnd_irq", irq, r.irq);
      check("rnd_pulse", ctrl_wr_pulse, r.pulse);
      check("rnd_ctrl", ctrl_out, r.ctrl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/engine_csr_bank.md
# engine_csr_bank

Parametrised control/status register bank for engine blocks, the successor to the single-register engine control block. It gives a bus master word-addressed access to NUM_CTRL read/write control registers, a sticky write-1-to-clear event status register, an interrupt-enable register and a read-only ID register. It adds byte strobes, registered reads with a valid flag, access-error reporting and a level interrupt output. It sits between the engine's register bus and the engine datapath.

## Interface
Parameters:
- DATA_W, 32, register width; must be a multiple of 8
- ADDR_W, 33, bus address width
- NUM_CTRL, 4, number of control registers; range 1..16
- BASE_ADDR, 'hAA, word address of control register 0
- CTRL_RESET, 0, reset value of every control register (DATA_W bits)
- ID_VALUE, 'hE5C0_0001, constant returned by the ID register

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- address  in  ADDR_W  word address
- write_enable  in  1  write request, one cycle
- write_data  in  DATA_W  write data
- write_strobe  in  DATA_W/8  byte enables for the write
- read_enable  in  1  read request, one cycle
- read_data  out  DATA_W  read data, registered
- read_valid  out  1  read_data is valid this cycle
- access_error  out  1  pulse for an unmapped or illegal access
- ctrl_out  out  NUM_CTRL*DATA_W  control registers, register i at bits [i*DATA_W +: DATA_W]
- ctrl_wr_pulse  out  NUM_CTRL  one-cycle pulse per control register written
- status_in  in  DATA_W  event bits, sampled every cycle
- irq  out  1  level interrupt

## Operation
Address map (offset from BASE_ADDR):
- 0..NUM_CTRL-1: CTRL[i], read/write
- NUM_CTRL: STATUS, sticky, write-1-to-clear
- NUM_CTRL+1: IRQ_EN, read/write
- NUM_CTRL+2: ID, read-only

Writes:
- Writes are byte-granular. For each asserted write_strobe bit k, byte k of the target register is updated; other bytes hold their value.
- A write to STATUS clears every bit that is written 1 in a strobed byte.
- If a status_in bit is set in the same cycle that a write clears it, the set wins and the bit stays 1.
- Any write to CTRL[i] (strobe not all zero) pulses ctrl_wr_pulse[i]. A write with all strobes zero is accepted but changes nothing and pulses nothing.

Reads:
- A read returns the full register. The STATUS value returned is the value before this cycle's update.
- A simultaneous read and write to the same address returns the old value; both operations are performed.

Errors:
- An address outside BASE_ADDR..BASE_ADDR+NUM_CTRL+2 is an error.
  - A write is ignored.
  - A read returns read_data = 0 with read_valid = 1.
  - access_error pulses in both cases.
- A write to ID is ignored and pulses access_error.
- Offset arithmetic is address − BASE_ADDR at ADDR_W bits. Any address below BASE_ADDR is unmapped; a wrapped difference must not alias a mapped offset.

Interrupt:
- irq = |(STATUS & IRQ_EN), registered.

Reset values (all outputs):
- CTRL = CTRL_RESET, STATUS = 0, IRQ_EN = 0
- read_data = 0, read_valid = 0, access_error = 0, ctrl_wr_pulse = 0, irq = 0

## Timing
- Read latency is 1: read_enable at edge T gives read_valid = 1 and read_data for the cycle after T only. read_data holds its last value afterwards.
- A write at edge T updates the register after T. ctrl_out changes and ctrl_wr_pulse is high for exactly the cycle after T.
- access_error is high for the one cycle after the offending edge. If a read and a write are both illegal in the same cycle, a single pulse is produced.
- A status_in bit high at edge T sets STATUS after T; irq rises after T+1. A clear at edge T drops irq after T+1.
- Back-to-back accesses every cycle are supported with no stalls.
- Reset asserted at any cycle, including with an access pending or in flight, forces every reset value at the next edge. The pending read_valid and pulses are discarded.

## Structure
- Package engine_csr_pkg holds:
  - offset constants: OFS_STATUS(n) = n, OFS_IRQ_EN(n) = n+1, OFS_ID(n) = n+2
  - a byte-merge function (old, new, strobe)
  - the decode result enum: CTRL, STATUS, IRQ_EN, ID, UNMAPPED
- One sub-module, engine_csr_sticky_status, implements STATUS: set/clear priority and the byte-strobed write-1-to-clear.

## Test plan
- Reset, then read every offset → CTRL = CTRL_RESET, STATUS = 0, IRQ_EN = 0, ID = 'hE5C0_0001; read_valid high 1 cycle after each read_enable.
- Write CTRL[2] with 'h1234_5678, strobe 4'b0101, over 'hAAAA_AAAA → reads 'hAA34_AA78; ctrl_wr_pulse[2] high exactly one cycle.
- Pulse status_in = 'h0000_0011 with IRQ_EN = 'h1 → irq rises 2 cycles after the pulse. Write STATUS with 'h1 → STATUS = 'h10 and irq falls. Set and clear bit 4 in the same cycle → bit 4 stays 1.
- Read address BASE_ADDR+NUM_CTRL+3 and BASE_ADDR−1 → read_data = 0, read_valid = 1, access_error one-cycle pulse. Write to ID → ID unchanged, access_error pulses.
- Same-cycle read and write of CTRL[0] ('h0 → 'hFFFF_FFFF) → read returns 'h0; the following read returns 'hFFFF_FFFF.
- Assert reset for one cycle immediately after a read_enable and a write → no read_valid, no ctrl_wr_pulse, all registers at reset values.
